if_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Holds the PC, runs a req/ack fetch on the instruction bus with arbitrary wait states, and presents pc/inst to decode.
- Honours decode stalls, branch redirects with one architectural delay slot, and exception flushes.

---
 rtl/if_stage_pkg.sv | 28 ++
 rtl/if_stage_pc_gen.sv | 56 +++++
 rtl/if_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus types, reset level,
// branch flag levels and the fetch FSM encoding.
package if_stage_pkg;

  localparam logic RstEnable = 1'b0;
  localparam logic Branch    = 1'b1;
  localparam logic NotBranch = 1'b0;

  localparam int InstAddrW = 32;
  localparam int InstW     = 32;

  typedef logic [InstAddrW-1:0] inst_addr_t;
  typedef logic [InstW-1:0]     inst_t;

  localparam inst_addr_t ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10,
    DRAIN = 2'b11
  } fetch_state_e;

  function automatic inst_addr_t align_word(input inst_addr_t a);
    return {a[InstAddrW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_gen.sv
// Fetch PC register with the delay-slot redirect latch and next-PC selection.
module if_stage_pc_gen
  import if_stage_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h8000_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_flush,
  input  inst_addr_t i_flush_pc,
  input  logic       i_advance,
  input  logic       i_branch_latch,
  input  logic       i_branch_direct,
  input  inst_addr_t i_branch_target,
  output inst_addr_t o_pc
);

  inst_addr_t r_pc;
  inst_addr_t r_target;
  logic       r_pending;
  inst_addr_t w_pc_inc;
  inst_addr_t w_next_pc;

  assign w_pc_inc = r_pc + 32'd4;

  // A branch resolved alongside the delay-slot ack (or during HOLD) wins
  // over any older pending redirect.
  always_comb begin
    w_next_pc = w_pc_inc;
    if (i_branch_direct) begin
      w_next_pc = align_word(i_branch_target);
    end else if (r_pending == Branch) begin
      w_next_pc = r_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_pc      <= align_word(RESET_PC);
      r_target  <= ZeroWord;
      r_pending <= NotBranch;
    end else if (i_flush) begin
      r_pc      <= align_word(i_flush_pc);
      r_pending <= NotBranch;
    end else if (i_advance || i_branch_direct) begin
      r_pc      <= w_next_pc;
      r_pending <= NotBranch;
    end else if (i_branch_latch) begin
      r_target  <= align_word(i_branch_target);
      r_pending <= Branch;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: req/ack bus FSM, one-entry stall hold buffer and
// the IF/ID pipeline register feeding decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h8000_0000,
  parameter inst_t      NOP_INST = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_i,
  input  logic       flush_i,
  input  inst_addr_t flush_pc_i,
  input  logic       branch_flag_i,
  input  inst_addr_t branch_target_i,
  output logic       ibus_req_o,
  output inst_addr_t ibus_addr_o,
  input  logic       ibus_ack_i,
  input  inst_t      ibus_data_i,
  output inst_addr_t pc_o,
  output inst_t      inst_o,
  output logic       inst_valid_o
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic         w_req;
  inst_addr_t   w_addr;
  inst_addr_t   w_pc;

  inst_addr_t   r_pc_o;
  inst_t        r_inst;
  logic         r_valid;
  inst_addr_t   r_hold_pc;
  inst_t        r_hold_inst;
  inst_addr_t   r_drain_addr;

  logic w_br_sample;
  logic w_advance;
  logic w_br_direct;
  logic w_br_latch;

  assign w_br_sample = (branch_flag_i == Branch) && !stall_i && !flush_i;
  assign w_advance   = (r_state == FETCH) && ibus_ack_i && !flush_i;
  assign w_br_direct = w_br_sample &&
                       (((r_state == FETCH) && ibus_ack_i) || (r_state == HOLD));
  assign w_br_latch  = w_br_sample && (r_state == FETCH) && !ibus_ack_i;

  if_stage_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk             (clk),
    .rst             (rst),
    .i_flush         (flush_i),
    .i_flush_pc      (flush_pc_i),
    .i_advance       (w_advance),
    .i_branch_latch  (w_br_latch),
    .i_branch_direct (w_br_direct),
    .i_branch_target (branch_target_i),
    .o_pc            (w_pc)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_addr       = ZeroWord;
    case (r_state)
      IDLE: begin
        w_state_next = FETCH;
      end
      FETCH: begin
        w_req  = 1'b1;
        w_addr = w_pc;
        if (ibus_ack_i && stall_i) begin
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (!stall_i) begin
          w_state_next = FETCH;
        end
      end
      DRAIN: begin
        w_req  = 1'b1;
        w_addr = r_drain_addr;
        if (ibus_ack_i) begin
          w_state_next = FETCH;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    // An unacknowledged request must still be completed on the bus.
    if (flush_i) begin
      w_state_next = (w_req && !ibus_ack_i) ? DRAIN : FETCH;
    end
  end

  assign ibus_req_o  = w_req;
  assign ibus_addr_o = w_addr;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_pc_o       <= ZeroWord;
      r_inst       <= NOP_INST;
      r_valid      <= 1'b0;
      r_hold_pc    <= ZeroWord;
      r_hold_inst  <= NOP_INST;
      r_drain_addr <= ZeroWord;
    end else if (flush_i) begin
      r_inst      <= NOP_INST;
      r_valid     <= 1'b0;
      r_hold_pc   <= ZeroWord;
      r_hold_inst <= NOP_INST;
      if (r_state == FETCH) begin
        r_drain_addr <= w_pc;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (ibus_ack_i) begin
            if (!stall_i) begin
              r_pc_o  <= w_pc;
              r_inst  <= ibus_data_i;
              r_valid <= 1'b1;
            end else begin
              r_hold_pc   <= w_pc;
              r_hold_inst <= ibus_data_i;
            end
          end else if (!stall_i) begin
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            r_pc_o  <= r_hold_pc;
            r_inst  <= r_hold_inst;
            r_valid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pc_o         = r_pc_o;
  assign inst_o       = r_inst;
  assign inst_valid_o = r_valid;

endmodule
